// File: rtl/i2c_register_bridge.sv
`default_nettype none
// ============================================================================
// Module   : i2c_register_bridge
// Function : Single-request valid/ready bridge onto the I2C master register
//            file; one-hot write/read strobes, registered read-back response.
//            Optional range check: I2C_REGISTER_BRIDGE_ADDR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_register_bridge #(
    parameter int REGS         = 9,
    parameter int ADDRESSWIDTH = $clog2(REGS),
    parameter int POWEROF2REGS = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [ADDRESSWIDTH-1:0]            req_addr,
    input  logic [31:0]                        req_wdata,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [31:0]                        rsp_rdata,
    output logic                               rsp_error,
    output logic                               reg_clk,
    output logic                               reg_reset,
    output logic [31:0]                        reg_data_in,
    input  logic [POWEROF2REGS-1:0][31:0]      reg_data_out,
    output logic [POWEROF2REGS-1:0]            reg_write_en,
    output logic [POWEROF2REGS-1:0]            reg_read_en
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    logic [1:0]              r_state;
    logic [ADDRESSWIDTH-1:0] r_addr;
    logic                    r_write;
    logic [31:0]             r_data_in;
    logic [31:0]             r_rdata;
    logic                    r_error;
    logic                    w_addr_ok;
    logic                    w_fire;

`ifdef I2C_REGISTER_BRIDGE_ADDR_CHECK_EN
    // One extra bit so REGS == 2**ADDRESSWIDTH still compares correctly.
    localparam logic [ADDRESSWIDTH:0] c_REGS = (ADDRESSWIDTH+1)'(REGS);
    assign w_addr_ok = ({1'b0, r_addr} < c_REGS);
`else
    assign w_addr_ok = 1'b1;
`endif

    assign w_fire    = (r_state == c_ACCESS) && w_addr_ok;

    assign req_ready   = (r_state == c_IDLE);
    assign rsp_valid   = (r_state == c_RESP);
    assign rsp_rdata   = r_rdata;
    assign rsp_error   = r_error;
    assign reg_clk     = clk;
    assign reg_reset   = reset;
    assign reg_data_in = r_data_in;

    for (genvar i = 0; i < POWEROF2REGS; i++) begin : g_strobe
        assign reg_write_en[i] = w_fire &&  r_write && (r_addr == ADDRESSWIDTH'(i));
        assign reg_read_en[i]  = w_fire && !r_write && (r_addr == ADDRESSWIDTH'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_data_in <= 32'd0;
            r_rdata   <= 32'd0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_write <= req_write;
                        // Write data persists on the bus until the next write.
                        if (req_write) begin
                            r_data_in <= req_wdata;
                        end
                        r_state <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    r_rdata <= (!r_write && w_addr_ok) ? reg_data_out[r_addr] : 32'd0;
                    r_error <= !w_addr_ok;
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_register_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_register_bridge
// Function : Directed vector bench for i2c_register_bridge with a model
//            register file. Expectations follow I2C_REGISTER_BRIDGE_ADDR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_register_bridge;

    logic                clk;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [3:0]          req_addr;
    logic [31:0]         req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_rdata;
    logic                rsp_error;
    logic                reg_clk;
    logic                reg_reset;
    logic [31:0]         reg_data_in;
    logic [15:0][31:0]   reg_data_out;
    logic [15:0]         reg_write_en;
    logic [15:0]         reg_read_en;

    int n_vec  = 0;
    int n_fail = 0;

    i2c_register_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .reg_clk      (reg_clk),
        .reg_reset    (reg_reset),
        .reg_data_in  (reg_data_in),
        .reg_data_out (reg_data_out),
        .reg_write_en (reg_write_en),
        .reg_read_en  (reg_read_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model register file, preset on reset, written by the write strobes.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) reg_data_out[i] <= 32'hFFFF_FFFF;
            reg_data_out[0]  <= 32'hA5A5_0000;
            reg_data_out[5]  <= 32'h1234_5678;
            reg_data_out[12] <= 32'h0C0C_0C0C;
        end else begin
            for (int i = 0; i < 16; i++)
                if (reg_write_en[i]) reg_data_out[i] <= reg_data_in;
        end
    end

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [15:0] exp_wr_en;
        logic [15:0] exp_rd_en;
        logic [31:0] exp_din;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts at the negedge of T0; returns at the negedge of T2 with rsp_ready=1.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk("req_ready_T0", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("wr_en_T1", {16'd0, reg_write_en}, {16'd0, v.exp_wr_en});
        chk("rd_en_T1", {16'd0, reg_read_en},  {16'd0, v.exp_rd_en});
        chk("data_in_T1", reg_data_in, v.exp_din);
        chk("rsp_valid_T1", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rsp_valid_T2", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_rdata_T2", rsp_rdata, v.exp_rdata);
        chk("rsp_error_T2", {31'd0, rsp_error}, {31'd0, v.exp_err});
        chk("strobes_T2", {reg_write_en, reg_read_en}, 32'd0);
    endtask

    initial begin
        //            wr    addr   wdata          wr_en     rd_en     din            rdata          err
        vecs[0] = '{1'b1, 4'd3,  32'hDEAD_BEEF, 16'h0008, 16'h0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 4'd5,  32'h0BAD_0BAD, 16'h0000, 16'h0020, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 4'd3,  32'h0000_0000, 16'h0000, 16'h0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b1, 4'd1,  32'h0000_1111, 16'h0002, 16'h0000, 32'h0000_1111, 32'h0000_0000, 1'b0};
        vecs[4] = '{1'b0, 4'd1,  32'h0000_0000, 16'h0000, 16'h0002, 32'h0000_1111, 32'h0000_1111, 1'b0};
`ifdef I2C_REGISTER_BRIDGE_ADDR_CHECK_EN
        vecs[5] = '{1'b0, 4'd12, 32'h0000_0000, 16'h0000, 16'h0000, 32'h0000_1111, 32'h0000_0000, 1'b1};
        vecs[6] = '{1'b1, 4'd15, 32'hCAFE_F00D, 16'h0000, 16'h0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b1};
`else
        vecs[5] = '{1'b0, 4'd12, 32'h0000_0000, 16'h0000, 16'h1000, 32'h0000_1111, 32'h0C0C_0C0C, 1'b0};
        vecs[6] = '{1'b1, 4'd15, 32'hCAFE_F00D, 16'h8000, 16'h0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
`endif
        vecs[7] = '{1'b0, 4'd8,  32'h0000_0000, 16'h0000, 16'h0100, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("reset_data_in", reg_data_in, 32'd0);
        chk("reset_strobes", {reg_write_en, reg_read_en}, 32'd0);
        chk("reg_reset_pass", {31'd0, reg_reset}, 32'd1);
        chk("reg_clk_pass", {31'd0, reg_clk}, {31'd0, clk});
        reset = 1'b0;

        // Back-to-back table vectors: each T0 check also covers the prior T3.
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        @(negedge clk);
        chk("req_ready_T3", {31'd0, req_ready}, 32'd1);
        chk("rsp_valid_T3", {31'd0, rsp_valid}, 32'd0);
        chk("reg_reset_low", {31'd0, reg_reset}, 32'd0);

        // Response stall: read addr 0 with rsp_ready low 4 cycles, second request waiting.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("stall_rd_en", {16'd0, reg_read_en}, 32'h0000_0001);
        req_addr = 4'd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rsp_rdata", rsp_rdata, 32'hA5A5_0000);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_strobes", {reg_write_en, reg_read_en}, 32'd0);
            if (c == 4) rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_stall_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_stall_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("held_req_rd_en", {16'd0, reg_read_en}, 32'h0000_0020);
        @(negedge clk);
        chk("held_req_rdata", rsp_rdata, 32'h1234_5678);
        chk("held_req_rsp_valid", {31'd0, rsp_valid}, 32'd1);

        // Reset asserted during ACCESS drops the transaction.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd2; req_wdata = 32'h0000_0055;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_access_wr_en", {16'd0, reg_write_en}, 32'h0000_0004);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wr_en_cleared", {reg_write_en, reg_read_en}, 32'd0);
        chk("rst_data_in", reg_data_in, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_register_bridge.md
# i2c_register_bridge

Bus-side driver for the I2C peripheral's register interface bundle. It accepts single register read/write requests from a host over a valid/ready channel and decodes the address into one-hot `write_en`/`read_en` strobes. It drives `data_in` to the register file, captures the selected `data_out` word, and returns it on a valid/ready response channel. It sits between the system bus adapter and the I2C master's register file.

## Interface
Parameters:
- `REGS`, 9, number of implemented registers.
- `ADDRESSWIDTH`, `$clog2(REGS)`, width of the request address.
- `POWEROF2REGS`, 16, number of decoded strobe/data lines; equals `2**ADDRESSWIDTH`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDRESSWIDTH  register index.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  host accepts the response.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_error`  out  1  address out of range (see Configuration).
- `reg_clk`  out  1  equals `clk` (pass-through).
- `reg_reset`  out  1  equals `reset` (pass-through).
- `reg_data_in`  out  32  write data to the register file.
- `reg_data_out`  in  32 × POWEROF2REGS  register read-back words.
- `reg_write_en`  out  1 × POWEROF2REGS  one-hot write strobes.
- `reg_read_en`  out  1 × POWEROF2REGS  one-hot read strobes.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch addr, write flag and wdata, then go to ACCESS.
- ACCESS lasts exactly one cycle.
  - Write: `reg_write_en[addr]`=1 and `reg_data_in`=latched wdata.
  - Read: `reg_read_en[addr]`=1, and `reg_data_out[addr]` is registered into `rsp_rdata` at the end of the cycle.
  - Always go to RESP.
- RESP:
  - `rsp_valid`=1.
  - `rsp_rdata` and `rsp_error` stay stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `req_ready`=0 in ACCESS and RESP; no request is accepted while one is outstanding.
- All strobe lines are 0 outside ACCESS. At most one strobe line is high in any cycle.
- `reg_data_in` holds the last written value until the next accepted write; reads do not alter it.
- A write response has `rsp_rdata`=0.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `reg_data_in`=0, all strobes 0.
- Reset asserted in any state (including ACCESS and RESP) returns the FSM to IDLE on the next edge. The pending transaction is dropped with no response, and strobes are 0 from that edge on.

## Timing
- T0: request handshake cycle.
- T1: ACCESS, strobe high for one cycle.
- T2: RESP, `rsp_valid` high with `rsp_rdata` valid.
- If `rsp_ready`=1 in T2, `req_ready`=1 in T3. Maximum throughput is one transaction per 3 cycles.
- The read path requires `reg_data_out` to be valid combinationally in the ACCESS cycle (register files read with zero latency).
- `rsp_ready` held low extends RESP indefinitely; outputs are unchanged during the stall.
- `reg_clk` and `reg_reset` are pure wires with no added delay.

## Configuration
- Macro: `I2C_REGISTER_BRIDGE_ADDR_CHECK_EN`.
- Defined:
  - An accepted address ≥ REGS still passes through ACCESS, but asserts no strobe.
  - The response carries `rsp_error`=1 and `rsp_rdata`=0.
- Not defined:
  - No range check is performed. Strobes fire for any address < POWEROF2REGS.
  - Reads return `reg_data_out[addr]`.
  - `rsp_error` is tied 0.

## Test plan
- Write addr 3, wdata 0xDEADBEEF, `rsp_ready`=1 → `reg_write_en[3]` high exactly in T1 with `reg_data_in`=0xDEADBEEF; `rsp_valid` in T2 with rdata 0; `req_ready` high in T3.
- Read addr 5 with `reg_data_out[5]`=0x12345678 and all other words 0xFFFFFFFF → only `reg_read_en[5]` pulses in T1; `rsp_rdata`=0x12345678 in T2. A subsequent read leaves `reg_data_in` unchanged.
- Read addr 0 with `rsp_ready` low for 4 cycles → `rsp_valid` held 5 cycles with constant rdata; `req_valid` held high during this time is not accepted (`req_ready`=0); accepted in the cycle after the response handshake.
- Address 12 (REGS=9):
  - With macro: no strobe, `rsp_error`=1, rdata 0.
  - Without macro: `reg_read_en[12]` pulses, rdata=`reg_data_out[12]`, `rsp_error`=0.
- Reset asserted in ACCESS → strobe deasserts at next edge; `rsp_valid` never rises; `req_ready`=1 after reset; `reg_data_in`=0.
- Back-to-back write addr 1 then read addr 1 with a model register file → read returns the written value; each strobe is one cycle wide.
